branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of table entries; power of two, 4..1024.
REQ-002 SHALL have parameter CTR_BITS, default 2, saturating counter width per entry; 1..4.
REQ-003 SHALL have parameter GHR_BITS, default 0, global history length; 0 = bimodal, >0 = gshare; at most log2(ENTRIES).
REQ-004 SHALL have parameter CNT_W, default 32, width of the statistics counters.
REQ-005 SHALL have CLK  in  1  clock, rising edge.
REQ-006 SHALL have RESET  in  1  asynchronous, active-low reset.
REQ-007 SHALL have Lookup_Valid_IN  in  1  fetch requests a prediction.
REQ-008 SHALL have Lookup_PC_IN  in  32  PC being fetched.
REQ-009 SHALL have Stall_IN  in  1  fetch frozen; hold all lookup outputs.
REQ-010 SHALL have Pred_Taken_OUT, Pred_Hit_OUT  out  1 each  prediction and target-tag hit.
REQ-011 SHALL have Pred_Target_OUT  out  32  predicted target.
REQ-012 SHALL have Update_Valid_IN  in  1  ID resolved one branch/jump this cycle.
REQ-013 SHALL have Update_PC_IN, Update_Target_IN, Update_Pred_Target_IN  in  32 each  branch PC, actual target, predicted target.
REQ-014 SHALL have Update_Taken_IN, Update_Pred_Taken_IN  in  1 each  actual outcome and predicted outcome.
REQ-015 SHALL have Flush_IN  in  1  reinitialise tables (used on syscall flush).
REQ-016 SHALL have Mispredict_OUT  out  1 and Correct_PC_OUT  out  32  redirect to fetch.
REQ-017 SHALL have Ready_OUT  out  1  tables initialised, predictions valid.
REQ-018 SHALL have Branch_Count_OUT, Miss_Count_OUT  out  CNT_W each  statistics.

Function
REQ-019 SHALL index = PC[IDX+1:2] XOR {zero-extended GHR}, IDX = log2(ENTRIES); tag = PC[31:IDX+2].
REQ-020 SHALL, per entry, hold CTR_BITS counter, valid bit, tag and 32-bit target.
REQ-021 SHALL register lookup outputs one cycle after Lookup_Valid_IN & !Stall_IN; Pred_Taken_OUT = counter MSB & Pred_Hit_OUT; Pred_Hit_OUT = valid & tag match; Pred_Target_OUT = stored target when hit, else 0.
REQ-022 SHALL, when Stall_IN=1, hold all lookup outputs unchanged.
REQ-023 SHALL, on Update_Valid_IN, increment counter if taken (saturate at all-ones), decrement if not taken (saturate at 0); if taken, write tag, target, valid=1.
REQ-024 SHALL shift Update_Taken_IN into GHR LSB on each update (GHR_BITS>0); GHR reset to 0.
REQ-025 SHALL assert Mispredict_OUT one cycle after update when taken != Pred_Taken, or taken & target != Pred_Target.
REQ-026 SHALL set Correct_PC_OUT = taken ? Update_Target_IN : Update_PC_IN+8 (delay-slot fall-through); 0 when no mispredict.
REQ-027 SHALL increment Branch_Count_OUT per update and Miss_Count_OUT per mispredict, both saturating at all-ones.
REQ-028 SHALL, on same-index lookup and update in one cycle, return pre-update state for the lookup (read-before-write).
REQ-029 SHALL implement FSM INIT -> RUN; INIT walks index 0..ENTRIES-1, one per cycle, writing counter = 2^(CTR_BITS-1)-1, valid=0; then RUN.
REQ-030 SHALL keep Ready_OUT=0 in INIT; lookups return Pred_Taken=0, Hit=0; updates ignored, not counted.
REQ-031 SHALL, on Flush_IN in RUN, enter INIT at index 0 and clear GHR; Flush_IN during INIT restarts at index 0; statistics retained.

Reset
REQ-032 SHALL, on RESET low, enter INIT at index 0; all outputs, GHR and statistics counters 0.
REQ-033 SHALL, on RESET mid-INIT or mid-RUN, abandon state and restart INIT after release.

Structure
REQ-034 SHALL place FSM state encoding and the counter-initial-value function in shared package bp_pkg.
REQ-035 SHALL use one sub-module, bp_sat_counter, for parametrised saturating increment/decrement.

Verification (ENTRIES=64, CTR_BITS=2, GHR_BITS=0)
REQ-036 SHALL: RESET release -> Ready_OUT=0 for 64 cycles then 1; lookup 0x00400100 -> Taken=0, Hit=0.
REQ-037 SHALL: two taken updates PC 0x00400100 target 0x00400200 (pred not-taken) -> Mispredict=1, Correct_PC=0x00400200; lookup then Taken=1, Hit=1, Target=0x00400200; Miss_Count=2, Branch_Count=2.
REQ-038 SHALL: five taken then one not-taken update at 0x00400100 -> lookup still Taken=1 (counter 3->2).
REQ-039 SHALL: train 0x00400100, lookup 0x00400200 (same index 0, tag differs) -> Hit=0, Taken=0.
REQ-040 SHALL: same-cycle lookup and taken update at 0x00400100 from counter 1 -> lookup Taken=0; next lookup Taken=1.
REQ-041 SHALL: Flush_IN in RUN -> Ready_OUT=0 for 64 cycles, prior entries miss, Miss_Count unchanged.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared FSM encoding and counter initial value for the branch predictor
package bp_pkg;
   typedef enum logic {ST_INIT, ST_RUN} bp_state_t;
   function automatic int ctr_init(input int bits);
      return (1 << (bits - 1)) - 1;
   endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: saturating increment/decrement of a W-bit value
module bp_sat_counter #(
   parameter int W = 2
) (
   input  logic [W-1:0] value,
   input  logic         en,
   input  logic         inc,
   output logic [W-1:0] next
);
   always_comb next = !en ? value : inc ? (&value ? value : value + W'(1)) : (|value ? value - W'(1) : value);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal/gshare predictor with tagged target table and miss statistics
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES  = 64,
   parameter int CTR_BITS = 2,
   parameter int GHR_BITS = 0,
   parameter int CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Lookup_Valid_IN,
   input  logic [31:0]      Lookup_PC_IN,
   input  logic             Stall_IN,
   output logic             Pred_Taken_OUT,
   output logic             Pred_Hit_OUT,
   output logic [31:0]      Pred_Target_OUT,
   input  logic             Update_Valid_IN,
   input  logic [31:0]      Update_PC_IN,
   input  logic [31:0]      Update_Target_IN,
   input  logic [31:0]      Update_Pred_Target_IN,
   input  logic             Update_Taken_IN,
   input  logic             Update_Pred_Taken_IN,
   input  logic             Flush_IN,
   output logic             Mispredict_OUT,
   output logic [31:0]      Correct_PC_OUT,
   output logic             Ready_OUT,
   output logic [CNT_W-1:0] Branch_Count_OUT,
   output logic [CNT_W-1:0] Miss_Count_OUT
);
   localparam int IDX = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX;
   localparam int GHR_W = GHR_BITS > 0 ? GHR_BITS : 1;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_init(CTR_BITS));

   bp_state_t state, state_nx;
   logic [IDX-1:0] init_idx, init_idx_nx;
   logic [GHR_W-1:0] ghr;
   logic [CTR_BITS-1:0] ctr_q [ENTRIES];
   logic [ENTRIES-1:0] vld_q;
   logic [TAG_W-1:0] tag_q [ENTRIES];
   logic [31:0] tgt_q [ENTRIES];
   logic [IDX-1:0] ghr_ext, lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic run, upd, lk_hit, mis;
   logic [CTR_BITS-1:0] ctr_nx;
   logic [CNT_W-1:0] br_nx, miss_nx;
   logic unused_pc_bits;

   assign unused_pc_bits = ^Lookup_PC_IN[1:0];
   assign ghr_ext = GHR_BITS > 0 ? IDX'(ghr) : '0;
   assign lk_idx  = Lookup_PC_IN[IDX+1:2] ^ ghr_ext;
   assign up_idx  = Update_PC_IN[IDX+1:2] ^ ghr_ext;
   assign lk_tag  = Lookup_PC_IN[31:IDX+2];
   assign up_tag  = Update_PC_IN[31:IDX+2];
   assign run     = state == ST_RUN;
   assign upd     = run && Update_Valid_IN && !Flush_IN;
   assign lk_hit  = run && vld_q[lk_idx] && tag_q[lk_idx] == lk_tag;
   assign mis     = upd && (Update_Taken_IN != Update_Pred_Taken_IN ||
                            (Update_Taken_IN && Update_Target_IN != Update_Pred_Target_IN));
   assign Ready_OUT = run;

   bp_sat_counter #(.W(CTR_BITS)) u_ctr (.value(ctr_q[up_idx]), .en(1'b1), .inc(Update_Taken_IN), .next(ctr_nx));
   bp_sat_counter #(.W(CNT_W)) u_br (.value(Branch_Count_OUT), .en(upd), .inc(1'b1), .next(br_nx));
   bp_sat_counter #(.W(CNT_W)) u_miss (.value(Miss_Count_OUT), .en(mis), .inc(1'b1), .next(miss_nx));

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= ST_INIT;
         init_idx <= '0;
      end else begin
         state    <= state_nx;
         init_idx <= init_idx_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      init_idx_nx = init_idx;
      if (Flush_IN) begin
         state_nx    = ST_INIT;
         init_idx_nx = '0;
      end else if (state == ST_INIT) begin
         init_idx_nx = init_idx + IDX'(1);
         state_nx    = &init_idx ? ST_RUN : ST_INIT;
      end
   end

   // Table storage needs no reset: INIT rewrites every counter and valid bit.
   always_ff @(posedge CLK) begin
      if (state == ST_INIT) begin
         ctr_q[init_idx] <= CTR_INIT;
         vld_q[init_idx] <= 1'b0;
      end else if (upd) begin
         ctr_q[up_idx] <= ctr_nx;
         if (Update_Taken_IN) begin
            vld_q[up_idx] <= 1'b1;
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= Update_Target_IN;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Pred_Taken_OUT   <= 1'b0;
         Pred_Hit_OUT     <= 1'b0;
         Pred_Target_OUT  <= '0;
         Mispredict_OUT   <= 1'b0;
         Correct_PC_OUT   <= '0;
         Branch_Count_OUT <= '0;
         Miss_Count_OUT   <= '0;
         ghr              <= '0;
      end else begin
         if (Lookup_Valid_IN && !Stall_IN) begin
            Pred_Hit_OUT    <= lk_hit;
            Pred_Taken_OUT  <= lk_hit && ctr_q[lk_idx][CTR_BITS-1];
            Pred_Target_OUT <= lk_hit ? tgt_q[lk_idx] : '0;
         end
         Mispredict_OUT   <= mis;
         Correct_PC_OUT   <= !mis ? '0 : Update_Taken_IN ? Update_Target_IN : Update_PC_IN + 32'd8;
         Branch_Count_OUT <= br_nx;
         Miss_Count_OUT   <= miss_nx;
         if (Flush_IN)
            ghr <= '0;
         else if (upd && GHR_BITS > 0)
            ghr <= GHR_W'({ghr, Update_Taken_IN});
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table plus stall, flush and reset sequences
module tb_branch_predictor;
   localparam logic [31:0] A  = 32'h0040_0100, T  = 32'h0040_0200, B = 32'h0040_0200;
   localparam logic [31:0] C  = 32'h0040_0104, TC = 32'h0040_0300;
   localparam logic [31:0] D  = 32'h0040_0108, TD = 32'h0040_0500;

   logic CLK = 1'b0, RESET = 1'b0;
   logic Lookup_Valid_IN = 1'b0, Stall_IN = 1'b0, Flush_IN = 1'b0;
   logic [31:0] Lookup_PC_IN = '0;
   logic Pred_Taken_OUT, Pred_Hit_OUT, Mispredict_OUT, Ready_OUT;
   logic [31:0] Pred_Target_OUT, Correct_PC_OUT, Branch_Count_OUT, Miss_Count_OUT;
   logic Update_Valid_IN = 1'b0, Update_Taken_IN = 1'b0, Update_Pred_Taken_IN = 1'b0;
   logic [31:0] Update_PC_IN = '0, Update_Target_IN = '0, Update_Pred_Target_IN = '0;
   int tests = 0, fails = 0, n;

   branch_predictor dut (
      .CLK(CLK), .RESET(RESET),
      .Lookup_Valid_IN(Lookup_Valid_IN), .Lookup_PC_IN(Lookup_PC_IN), .Stall_IN(Stall_IN),
      .Pred_Taken_OUT(Pred_Taken_OUT), .Pred_Hit_OUT(Pred_Hit_OUT), .Pred_Target_OUT(Pred_Target_OUT),
      .Update_Valid_IN(Update_Valid_IN), .Update_PC_IN(Update_PC_IN), .Update_Target_IN(Update_Target_IN),
      .Update_Pred_Target_IN(Update_Pred_Target_IN), .Update_Taken_IN(Update_Taken_IN),
      .Update_Pred_Taken_IN(Update_Pred_Taken_IN), .Flush_IN(Flush_IN),
      .Mispredict_OUT(Mispredict_OUT), .Correct_PC_OUT(Correct_PC_OUT), .Ready_OUT(Ready_OUT),
      .Branch_Count_OUT(Branch_Count_OUT), .Miss_Count_OUT(Miss_Count_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic uv; logic [31:0] upc, utgt; logic ut, upt; logic [31:0] uptgt, lpc;
      logic mis; logic [31:0] cpc; logic tk, hit; logic [31:0] tgt, br, miss;
   } vec_t;
   vec_t vecs [18];

   function automatic vec_t mk(input logic uv, input logic [31:0] upc, utgt, input logic ut, upt,
                               input logic [31:0] uptgt, lpc, input logic mis, input logic [31:0] cpc,
                               input logic tk, hit, input logic [31:0] tgt, br, miss);
      vec_t v;
      v.uv = uv; v.upc = upc; v.utgt = utgt; v.ut = ut; v.upt = upt; v.uptgt = uptgt; v.lpc = lpc;
      v.mis = mis; v.cpc = cpc; v.tk = tk; v.hit = hit; v.tgt = tgt; v.br = br; v.miss = miss;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_upd(input logic uv, input logic [31:0] upc, utgt, input logic ut, upt,
                            input logic [31:0] uptgt);
      Update_Valid_IN = uv; Update_PC_IN = upc; Update_Target_IN = utgt;
      Update_Taken_IN = ut; Update_Pred_Taken_IN = upt; Update_Pred_Target_IN = uptgt;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ready(input string name, input int start);
      n = start;
      while (!Ready_OUT && n < 200) begin
         tick();
         n++;
      end
      check(name, n, 64);
   endtask

   initial begin
      vecs[0]  = mk(0, 0, 0,  0, 0, 0,  A, 0, 0,          0, 0, 0,  0,  0);
      vecs[1]  = mk(1, A, T,  1, 0, 0,  A, 1, T,          0, 0, 0,  1,  1);
      vecs[2]  = mk(1, A, T,  1, 0, 0,  A, 1, T,          1, 1, T,  2,  2);
      vecs[3]  = mk(0, 0, 0,  0, 0, 0,  A, 0, 0,          1, 1, T,  2,  2);
      vecs[4]  = mk(1, A, T,  1, 1, T,  A, 0, 0,          1, 1, T,  3,  2);
      vecs[5]  = mk(1, A, T,  1, 1, T,  A, 0, 0,          1, 1, T,  4,  2);
      vecs[6]  = mk(1, A, T,  1, 1, T,  A, 0, 0,          1, 1, T,  5,  2);
      vecs[7]  = mk(1, A, T,  0, 1, T,  A, 1, 32'h0040_0108, 1, 1, T, 6, 3);
      vecs[8]  = mk(0, 0, 0,  0, 0, 0,  A, 0, 0,          1, 1, T,  6,  3);
      vecs[9]  = mk(0, 0, 0,  0, 0, 0,  B, 0, 0,          0, 0, 0,  6,  3);
      vecs[10] = mk(1, C, TC, 1, 0, 0,  C, 1, TC,         0, 0, 0,  7,  4);
      vecs[11] = mk(0, 0, 0,  0, 0, 0,  C, 0, 0,          1, 1, TC, 7,  4);
      vecs[12] = mk(1, C, TC, 1, 1, 32'h0040_0400, C, 1, TC, 1, 1, TC, 8, 5);
      vecs[13] = mk(1, D, 0,  0, 0, 0,  D, 0, 0,          0, 0, 0,  9,  5);
      vecs[14] = mk(1, D, 0,  0, 0, 0,  D, 0, 0,          0, 0, 0,  10, 5);
      vecs[15] = mk(1, D, TD, 1, 0, 0,  D, 1, TD,         0, 0, 0,  11, 6);
      vecs[16] = mk(1, D, TD, 1, 0, 0,  D, 1, TD,         0, 1, TD, 12, 7);
      vecs[17] = mk(0, 0, 0,  0, 0, 0,  D, 0, 0,          1, 1, TD, 12, 7);

      #12;
      check("reset ready", Ready_OUT, 0);
      check("reset hit", Pred_Hit_OUT, 0);
      check("reset branch count", Branch_Count_OUT, 0);
      check("reset correct pc", Correct_PC_OUT, 0);
      #10 RESET = 1'b1;
      wait_ready("init cycles", 0);

      Lookup_Valid_IN = 1'b1;
      foreach (vecs[i]) begin
         drive_upd(vecs[i].uv, vecs[i].upc, vecs[i].utgt, vecs[i].ut, vecs[i].upt, vecs[i].uptgt);
         Lookup_PC_IN = vecs[i].lpc;
         tick();
         check($sformatf("v%0d mispredict", i), Mispredict_OUT, vecs[i].mis);
         check($sformatf("v%0d correct_pc", i), Correct_PC_OUT, vecs[i].cpc);
         check($sformatf("v%0d taken", i), Pred_Taken_OUT, vecs[i].tk);
         check($sformatf("v%0d hit", i), Pred_Hit_OUT, vecs[i].hit);
         check($sformatf("v%0d target", i), Pred_Target_OUT, vecs[i].tgt);
         check($sformatf("v%0d branches", i), Branch_Count_OUT, vecs[i].br);
         check($sformatf("v%0d misses", i), Miss_Count_OUT, vecs[i].miss);
      end
      drive_upd(0, 0, 0, 0, 0, 0);

      Lookup_PC_IN = A;
      tick();
      check("stall pre hit", Pred_Hit_OUT, 1);
      Stall_IN = 1'b1; Lookup_PC_IN = B;
      tick();
      check("stall hold hit", Pred_Hit_OUT, 1);
      check("stall hold target", Pred_Target_OUT, T);
      check("stall hold taken", Pred_Taken_OUT, 1);
      Stall_IN = 1'b0;
      tick();
      check("unstall hit", Pred_Hit_OUT, 0);

      Flush_IN = 1'b1; Lookup_PC_IN = A;
      tick();
      Flush_IN = 1'b0;
      check("flush ready", Ready_OUT, 0);
      drive_upd(1, A, T, 1, 0, 0);
      tick();
      drive_upd(0, 0, 0, 0, 0, 0);
      check("init update ignored mis", Mispredict_OUT, 0);
      check("init update not counted", Branch_Count_OUT, 12);
      check("init lookup hit", Pred_Hit_OUT, 0);
      check("init lookup taken", Pred_Taken_OUT, 0);
      wait_ready("flush init cycles", 1);
      tick();
      check("post flush hit", Pred_Hit_OUT, 0);
      check("post flush taken", Pred_Taken_OUT, 0);
      check("post flush misses", Miss_Count_OUT, 7);
      check("post flush branches", Branch_Count_OUT, 12);

      Lookup_PC_IN = C;
      Flush_IN = 1'b1;
      tick();
      Flush_IN = 1'b0;
      repeat (10) tick();
      #2 RESET = 1'b0;
      #1;
      check("mid-init reset branches", Branch_Count_OUT, 0);
      check("mid-init reset misses", Miss_Count_OUT, 0);
      check("mid-init reset ready", Ready_OUT, 0);
      repeat (2) tick();
      #3 RESET = 1'b1;
      wait_ready("reset init cycles", 0);
      tick();
      check("post reset hit", Pred_Hit_OUT, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
